// File: rtl/rgb2yuv444.sv
// RGB888 -> YUV444 converter (BT.601 full range; studio range under RGB2YUV_LIMITED_RANGE_EN), plus per-frame pixel audit.
// Latency: fixed 3 cycles, one pixel per clock.
// Backpressure: none; every valid input pixel is accepted.
module rgb2yuv444 #(
    parameter int FRAME_PIXELS = 2073600,
    parameter int CNT_BITS     = 22
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rgb_data_valid,
    input  logic [23:0]         rgb_data,
    input  logic                EOF,
    output logic                yuv_data_valid,
    output logic [23:0]         yuv_data,
    output logic                yuv_eof,
    output logic                frame_done,
    output logic                frame_err,
    output logic [CNT_BITS-1:0] frame_pix_cnt
);

`ifdef RGB2YUV_LIMITED_RANGE_EN
    localparam logic [7:0] K_YR = 8'd66,  K_YG = 8'd129, K_YB = 8'd25;
    localparam logic [7:0] K_UR = 8'd38,  K_UG = 8'd74,  K_UB = 8'd112;
    localparam logic [7:0] K_VR = 8'd112, K_VG = 8'd94,  K_VB = 8'd18;
    localparam logic signed [17:0] Y_OFS = 18'sd16;
    localparam logic signed [17:0] Y_MIN = 18'sd16, Y_MAX = 18'sd235;
    localparam logic signed [17:0] C_MIN = 18'sd16, C_MAX = 18'sd240;
`else
    localparam logic [7:0] K_YR = 8'd77,  K_YG = 8'd150, K_YB = 8'd29;
    localparam logic [7:0] K_UR = 8'd43,  K_UG = 8'd85,  K_UB = 8'd128;
    localparam logic [7:0] K_VR = 8'd128, K_VG = 8'd107, K_VB = 8'd21;
    localparam logic signed [17:0] Y_OFS = 18'sd0;
    localparam logic signed [17:0] Y_MIN = 18'sd0, Y_MAX = 18'sd255;
    localparam logic signed [17:0] C_MIN = 18'sd0, C_MAX = 18'sd255;
`endif

    localparam logic [CNT_BITS-1:0] CNT_MAX   = '1;
    localparam logic [CNT_BITS-1:0] FRAME_CNT = CNT_BITS'(FRAME_PIXELS);

    function automatic logic signed [17:0] ext(input logic [15:0] p);
        return $signed({2'b00, p});
    endfunction

    function automatic logic [7:0] clamp8(input logic signed [17:0] x,
                                          input logic signed [17:0] lo,
                                          input logic signed [17:0] hi);
        logic [7:0] r;
        if (x < lo)      r = lo[7:0];
        else if (x > hi) r = hi[7:0];
        else             r = x[7:0];
        return r;
    endfunction

    logic [7:0] r_in, g_in, b_in;
    assign r_in = rgb_data[23:16];
    assign g_in = rgb_data[15:8];
    assign b_in = rgb_data[7:0];

    logic [2:0]               vld_d, vld_q, eof_d, eof_q;
    logic [15:0]              prod_d [9];
    logic [15:0]              prod_q [9];
    logic signed [17:0]       y_sum_d, u_sum_d, v_sum_d;
    logic signed [17:0]       y_sum_q, u_sum_q, v_sum_q;
    logic [23:0]              yuv_data_d, yuv_data_q;
    logic [CNT_BITS-1:0]      pix_cnt_d, pix_cnt_q;
    logic [CNT_BITS-1:0]      frame_pix_cnt_d, frame_pix_cnt_q;
    logic                     frame_done_d, frame_done_q;
    logic                     frame_err_d, frame_err_q;
    logic [CNT_BITS:0]        cnt_inc;
    logic [CNT_BITS-1:0]      cnt_sat;

    always_comb begin
        vld_d = {vld_q[1:0], rgb_data_valid};
        eof_d = {eof_q[1:0], EOF & rgb_data_valid};

        // Stage 1: unsigned coefficient magnitudes; signs are applied in stage 2.
        prod_d[0] = 16'(r_in) * 16'(K_YR);
        prod_d[1] = 16'(g_in) * 16'(K_YG);
        prod_d[2] = 16'(b_in) * 16'(K_YB);
        prod_d[3] = 16'(r_in) * 16'(K_UR);
        prod_d[4] = 16'(g_in) * 16'(K_UG);
        prod_d[5] = 16'(b_in) * 16'(K_UB);
        prod_d[6] = 16'(r_in) * 16'(K_VR);
        prod_d[7] = 16'(g_in) * 16'(K_VG);
        prod_d[8] = 16'(b_in) * 16'(K_VB);

        y_sum_d = 18'sd128 + ext(prod_q[0]) + ext(prod_q[1]) + ext(prod_q[2]);
        u_sum_d = 18'sd128 - ext(prod_q[3]) - ext(prod_q[4]) + ext(prod_q[5]);
        v_sum_d = 18'sd128 + ext(prod_q[6]) - ext(prod_q[7]) - ext(prod_q[8]);

        yuv_data_d = yuv_data_q;
        if (vld_q[1]) begin
            yuv_data_d = {clamp8((y_sum_q >>> 8) + Y_OFS,   Y_MIN, Y_MAX),
                          clamp8((u_sum_q >>> 8) + 18'sd128, C_MIN, C_MAX),
                          clamp8((v_sum_q >>> 8) + 18'sd128, C_MIN, C_MAX)};
        end
    end

    // Frame audit runs on the output stream so counts line up with yuv_eof.
    always_comb begin
        cnt_inc         = {1'b0, pix_cnt_q} + (CNT_BITS+1)'(1);
        cnt_sat         = cnt_inc[CNT_BITS] ? CNT_MAX : cnt_inc[CNT_BITS-1:0];
        pix_cnt_d       = pix_cnt_q;
        frame_pix_cnt_d = frame_pix_cnt_q;
        frame_done_d    = 1'b0;
        frame_err_d     = frame_err_q;
        if (vld_q[2]) begin
            if (eof_q[2]) begin
                pix_cnt_d       = '0;
                frame_pix_cnt_d = cnt_sat;
                frame_done_d    = 1'b1;
                if (cnt_sat != FRAME_CNT) frame_err_d = 1'b1;
            end else begin
                pix_cnt_d = cnt_sat;
                if (cnt_sat == CNT_MAX) frame_err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            vld_q           <= '0;
            eof_q           <= '0;
            for (int i = 0; i < 9; i++) prod_q[i] <= '0;
            y_sum_q         <= '0;
            u_sum_q         <= '0;
            v_sum_q         <= '0;
            yuv_data_q      <= '0;
            pix_cnt_q       <= '0;
            frame_pix_cnt_q <= '0;
            frame_done_q    <= 1'b0;
            frame_err_q     <= 1'b0;
        end else begin
            vld_q           <= vld_d;
            eof_q           <= eof_d;
            for (int i = 0; i < 9; i++) prod_q[i] <= prod_d[i];
            y_sum_q         <= y_sum_d;
            u_sum_q         <= u_sum_d;
            v_sum_q         <= v_sum_d;
            yuv_data_q      <= yuv_data_d;
            pix_cnt_q       <= pix_cnt_d;
            frame_pix_cnt_q <= frame_pix_cnt_d;
            frame_done_q    <= frame_done_d;
            frame_err_q     <= frame_err_d;
        end
    end

    assign yuv_data_valid = vld_q[2];
    assign yuv_eof        = eof_q[2];
    assign yuv_data       = yuv_data_q;
    assign frame_done     = frame_done_q;
    assign frame_err      = frame_err_q;
    assign frame_pix_cnt  = frame_pix_cnt_q;

endmodule

// File: tb/tb_rgb2yuv444.sv
// Bench for rgb2yuv444: directed colour vectors, random stream against a reference model,
// frame audit, mid-flight reset and stray-EOF handling. FRAME_PIXELS shrunk to 64.
module tb_rgb2yuv444;
    localparam int FP = 64;
    localparam int CB = 22;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          rgb_data_valid = 1'b0;
    logic [23:0]   rgb_data = '0;
    logic          EOF = 1'b0;
    logic          yuv_data_valid;
    logic [23:0]   yuv_data;
    logic          yuv_eof;
    logic          frame_done;
    logic          frame_err;
    logic [CB-1:0] frame_pix_cnt;

    always #5 clk = ~clk;

    rgb2yuv444 #(.FRAME_PIXELS(FP), .CNT_BITS(CB)) dut (
        .clk            (clk),
        .rst            (rst),
        .rgb_data_valid (rgb_data_valid),
        .rgb_data       (rgb_data),
        .EOF            (EOF),
        .yuv_data_valid (yuv_data_valid),
        .yuv_data       (yuv_data),
        .yuv_eof        (yuv_eof),
        .frame_done     (frame_done),
        .frame_err      (frame_err),
        .frame_pix_cnt  (frame_pix_cnt)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        logic [23:0] dat;
        logic        eof;
        int          t;
    } exp_t;
    exp_t q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle();
        rgb_data_valid = 1'b0;
        EOF            = 1'b0;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b0;
        idle();
        repeat (n) tick();
        rst = 1'b1;
    endtask

    function automatic int lim(input int x, input int lo, input int hi);
        return (x < lo) ? lo : (x > hi) ? hi : x;
    endfunction

    function automatic logic [23:0] model(input logic [23:0] p);
        int r, g, b, y, u, v;
        r = int'(p[23:16]);
        g = int'(p[15:8]);
        b = int'(p[7:0]);
`ifdef RGB2YUV_LIMITED_RANGE_EN
        y = lim(((66 * r + 129 * g + 25 * b + 128) >>> 8) + 16, 16, 235);
        u = lim(((-38 * r - 74 * g + 112 * b + 128) >>> 8) + 128, 16, 240);
        v = lim(((112 * r - 94 * g - 18 * b + 128) >>> 8) + 128, 16, 240);
`else
        y = lim((77 * r + 150 * g + 29 * b + 128) >>> 8, 0, 255);
        u = lim(((-43 * r - 85 * g + 128 * b + 128) >>> 8) + 128, 0, 255);
        v = lim(((128 * r - 107 * g - 21 * b + 128) >>> 8) + 128, 0, 255);
`endif
        return {y[7:0], u[7:0], v[7:0]};
    endfunction

    task automatic stream_mon();
        exp_t e;
        if (yuv_data_valid) begin
            if (q.size() == 0) begin
                check("strm_extra", 32'(yuv_data_valid), 32'd0);
            end else begin
                e = q.pop_front();
                check("strm_dat", 32'(yuv_data), 32'(e.dat));
                check("strm_eof", 32'(yuv_eof), 32'(e.eof));
                check("strm_lat", 32'(cyc), 32'(e.t + 3));
            end
        end
    endtask

    // Hand-computed vectors: white, black, red, blue, green.
    logic [23:0] dir_in  [5] = '{24'hFFFFFF, 24'h000000, 24'hFF0000, 24'h0000FF, 24'h00FF00};
`ifdef RGB2YUV_LIMITED_RANGE_EN
    logic [23:0] dir_exp [5] = '{24'hEB8080, 24'h108080, 24'h525AF0, 24'h29F06E, 24'h903622};
`else
    logic [23:0] dir_exp [5] = '{24'hFF8080, 24'h008080, 24'h4D55FF, 24'h1DFF6B, 24'h952B15};
`endif

    initial begin
        int          sent;
        int          done_n;
        int          nv;
        int          first;
        int          n_eof;
        int          n_done;
        logic [31:0] cnts [2];
        logic [31:0] errs [2];
        logic [23:0] dat;

        // Reset state
        do_reset(4);
        rst = 1'b0;
        tick();
        check("rst_vld",  32'(yuv_data_valid), 32'd0);
        check("rst_dat",  32'(yuv_data),       32'd0);
        check("rst_eof",  32'(yuv_eof),        32'd0);
        check("rst_done", 32'(frame_done),     32'd0);
        check("rst_err",  32'(frame_err),      32'd0);
        check("rst_cnt",  32'(frame_pix_cnt),  32'd0);
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("idle_vld", 32'(yuv_data_valid), 32'd0);
        end

        // Directed single pixels, 3-cycle latency
        for (int i = 0; i < 5; i++) begin
            rgb_data_valid = 1'b1;
            rgb_data       = dir_in[i];
            tick();
            idle();
            tick();
            check("dir_early", 32'(yuv_data_valid), 32'd0);
            tick();
            check("dir_vld", 32'(yuv_data_valid), 32'd1);
            check("dir_dat", 32'(yuv_data),       32'(dir_exp[i]));
            tick();
            check("dir_pulse", 32'(yuv_data_valid), 32'd0);
            check("dir_hold",  32'(yuv_data),       32'(dir_exp[i]));
        end

        // Random stream with gaps and occasional EOF (some without valid)
        sent = 0;
        while (sent < 1000) begin
            rgb_data_valid = ($urandom_range(3) != 0);
            rgb_data       = 24'($urandom);
            EOF            = ($urandom_range(19) == 0);
            if (rgb_data_valid) begin
                q.push_back('{model(rgb_data), EOF, cyc});
                sent++;
            end
            tick();
            stream_mon();
        end
        idle();
        for (int i = 0; i < 6; i++) begin
            tick();
            stream_mon();
        end
        check("strm_left", 32'(q.size()), 32'd0);

        // Exact frame followed back-to-back by a short frame
        do_reset(2);
        done_n = 0;
        for (int i = 0; i < 135; i++) begin
            if (i < 127) begin
                rgb_data_valid = 1'b1;
                rgb_data       = 24'(i * 3);
                EOF            = (i == 63) || (i == 126);
            end else begin
                idle();
            end
            tick();
            if (frame_done) begin
                if (done_n < 2) begin
                    cnts[done_n] = 32'(frame_pix_cnt);
                    errs[done_n] = 32'(frame_err);
                end
                done_n++;
            end
        end
        check("frm_pulses", 32'(done_n), 32'd2);
        check("frm1_cnt",   cnts[0], 32'd64);
        check("frm1_err",   errs[0], 32'd0);
        check("frm2_cnt",   cnts[1], 32'd63);
        check("frm2_err",   errs[1], 32'd1);
        repeat (5) tick();
        check("err_sticky", 32'(frame_err),  32'd1);
        check("done_low",   32'(frame_done), 32'd0);

        // Reset with two pixels in flight
        do_reset(2);
        rgb_data_valid = 1'b1;
        rgb_data       = 24'h123456;
        tick();
        rgb_data       = 24'h654321;
        tick();
        rst = 1'b0;
        idle();
        tick();
        check("mid_vld", 32'(yuv_data_valid), 32'd0);
        check("mid_err", 32'(frame_err),      32'd0);
        check("mid_cnt", 32'(frame_pix_cnt),  32'd0);
        rst            = 1'b1;
        rgb_data_valid = 1'b1;
        rgb_data       = dir_in[0];
        EOF            = 1'b1;
        nv = 0; first = 0; dat = '0; n_done = 0;
        for (int k = 1; k <= 6; k++) begin
            tick();
            idle();
            if (yuv_data_valid) begin
                nv++;
                if (nv == 1) begin
                    first = k;
                    dat   = yuv_data;
                end
            end
            if (frame_done) n_done++;
        end
        check("mid_nout",   32'(nv),            32'd1);
        check("mid_lat",    32'(first),         32'd3);
        check("mid_dat",    32'(dat),           32'(dir_exp[0]));
        check("mid_done",   32'(n_done),        32'd1);
        check("mid_restrt", 32'(frame_pix_cnt), 32'd1);

        // EOF without valid is ignored
        n_eof = 0; n_done = 0;
        for (int i = 0; i < 11; i++) begin
            if (i < 3) begin
                rgb_data_valid = 1'b1;
                rgb_data       = 24'(i + 1);
                EOF            = 1'b0;
            end else if (i < 5) begin
                rgb_data_valid = 1'b0;
                EOF            = 1'b1;
            end else begin
                idle();
            end
            tick();
            if (yuv_eof)    n_eof++;
            if (frame_done) n_done++;
        end
        check("stray_eof",  32'(n_eof),         32'd0);
        check("stray_done", 32'(n_done),        32'd0);
        check("stray_cnt",  32'(frame_pix_cnt), 32'd1);
        rgb_data_valid = 1'b1;
        rgb_data       = 24'h0;
        EOF            = 1'b1;
        n_done = 0;
        for (int k = 0; k < 8; k++) begin
            tick();
            idle();
            if (frame_done) n_done++;
        end
        check("tail_done", 32'(n_done),        32'd1);
        check("tail_cnt",  32'(frame_pix_cnt), 32'd4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
